// File: rtl/round_manager.sv
`default_nettype none
// ============================================================================
// Module   : round_manager
// Purpose  : Round/match sequencer: HP bookkeeping, round clock, KO/time-out
//            resolution, win counting and fight gating for the HUD.
// Revision : 1.0 - initial release
// ============================================================================
module round_manager #(
  parameter int HP_MAX         = 100,
  parameter int DMG_LIGHT      = 8,
  parameter int DMG_HEAVY      = 14,
  parameter int FRAMES_PER_SEC = 60,
  parameter int ROUND_SECONDS  = 99,
  parameter int INTRO_FRAMES   = 120,
  parameter int KO_FRAMES      = 90,
  parameter int WINS_TO_MATCH  = 2,
  parameter int MAX_ROUNDS     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCEN,
  input  logic       start,
  input  logic       p1_hit_event,
  input  logic       p2_hit_event,
  input  logic [1:0] p1_attack_type,
  input  logic [1:0] p2_attack_type,
  output logic [7:0] p1_hp,
  output logic [7:0] p2_hp,
  output logic [6:0] round_time,
  output logic [2:0] round_state,
  output logic [2:0] round_num,
  output logic [1:0] p1_wins,
  output logic [1:0] p2_wins,
  output logic       fight_enable,
  output logic       match_over,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INTRO      = 3'd1,
    ST_FIGHT      = 3'd2,
    ST_KO         = 3'd3,
    ST_MATCH_OVER = 3'd4
  } state_e;

  localparam logic [7:0]  c_hp_max        = 8'(HP_MAX);
  localparam logic [7:0]  c_dmg_light     = 8'(DMG_LIGHT);
  localparam logic [7:0]  c_dmg_heavy     = 8'(DMG_HEAVY);
  localparam logic [6:0]  c_round_seconds = 7'(ROUND_SECONDS);
  localparam logic [15:0] c_fps_last      = 16'(FRAMES_PER_SEC - 1);
  localparam logic [15:0] c_intro_last    = 16'(INTRO_FRAMES - 1);
  localparam logic [15:0] c_ko_last       = 16'(KO_FRAMES - 1);
  localparam logic [1:0]  c_wins_to_match = 2'(WINS_TO_MATCH);
  localparam logic [2:0]  c_max_rounds    = 3'(MAX_ROUNDS);

  state_e      state_q, state_d;
  logic [7:0]  p1_hp_q, p1_hp_d;
  logic [7:0]  p2_hp_q, p2_hp_d;
  logic [6:0]  round_time_q, round_time_d;
  logic [2:0]  round_num_q, round_num_d;
  logic [1:0]  p1_wins_q, p1_wins_d;
  logic [1:0]  p2_wins_q, p2_wins_d;
  logic [1:0]  winner_q, winner_d;
  logic        fight_enable_q, fight_enable_d;
  logic        match_over_q, match_over_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] phase_cnt_q, phase_cnt_d;

  logic [7:0]  w_p1_hp_hit;
  logic [7:0]  w_p2_hp_hit;
  logic        w_frame_wrap;
  logic [6:0]  w_round_time_tick;
  logic        w_ko;
  logic        w_timeout;
  logic        w_load_round;

  function automatic logic [7:0] hit_damage(input logic [1:0] attack_type);
    return (attack_type == 2'd2) ? c_dmg_heavy : c_dmg_light;
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] hp, input logic [7:0] dmg);
    return (hp > dmg) ? (hp - dmg) : 8'd0;
  endfunction

  // A player's HP is reduced by the damage of the *opponent's* attack type.
  always_comb begin
    w_p1_hp_hit       = p1_hit_event ? sat_sub(p1_hp_q, hit_damage(p2_attack_type)) : p1_hp_q;
    w_p2_hp_hit       = p2_hit_event ? sat_sub(p2_hp_q, hit_damage(p1_attack_type)) : p2_hp_q;
    w_frame_wrap      = (frame_cnt_q == c_fps_last);
    w_round_time_tick = (w_frame_wrap && (round_time_q != 7'd0)) ? (round_time_q - 7'd1)
                                                                 : round_time_q;
    w_ko              = (w_p1_hp_hit == 8'd0) || (w_p2_hp_hit == 8'd0);
    w_timeout         = (w_round_time_tick == 7'd0);
  end

  always_comb begin
    state_d        = state_q;
    p1_hp_d        = p1_hp_q;
    p2_hp_d        = p2_hp_q;
    round_time_d   = round_time_q;
    round_num_d    = round_num_q;
    p1_wins_d      = p1_wins_q;
    p2_wins_d      = p2_wins_q;
    winner_d       = winner_q;
    frame_cnt_d    = frame_cnt_q;
    phase_cnt_d    = phase_cnt_q;
    w_load_round   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_INTRO;
          round_num_d  = 3'd1;
          w_load_round = 1'b1;
        end
      end

      ST_INTRO: begin
        if (phase_cnt_q == c_intro_last) begin
          state_d     = ST_FIGHT;
          phase_cnt_d = 16'd0;
        end else begin
          phase_cnt_d = phase_cnt_q + 16'd1;
        end
      end

      ST_FIGHT: begin
        p1_hp_d      = w_p1_hp_hit;
        p2_hp_d      = w_p2_hp_hit;
        round_time_d = w_round_time_tick;
        frame_cnt_d  = w_frame_wrap ? 16'd0 : (frame_cnt_q + 16'd1);
        if (w_ko || w_timeout) begin
          state_d     = ST_KO;
          phase_cnt_d = 16'd0;
          // KO takes precedence over a simultaneous time-out.
          if (w_ko) begin
            if ((w_p2_hp_hit == 8'd0) && (w_p1_hp_hit != 8'd0)) begin
              p1_wins_d = p1_wins_q + 2'd1;
            end else if ((w_p1_hp_hit == 8'd0) && (w_p2_hp_hit != 8'd0)) begin
              p2_wins_d = p2_wins_q + 2'd1;
            end
          end else if (w_p1_hp_hit > w_p2_hp_hit) begin
            p1_wins_d = p1_wins_q + 2'd1;
          end else if (w_p2_hp_hit > w_p1_hp_hit) begin
            p2_wins_d = p2_wins_q + 2'd1;
          end
        end
      end

      ST_KO: begin
        if (phase_cnt_q == c_ko_last) begin
          phase_cnt_d = 16'd0;
          if (p1_wins_q == c_wins_to_match) begin
            state_d  = ST_MATCH_OVER;
            winner_d = 2'd1;
          end else if (p2_wins_q == c_wins_to_match) begin
            state_d  = ST_MATCH_OVER;
            winner_d = 2'd2;
          end else if (round_num_q == c_max_rounds) begin
            state_d  = ST_MATCH_OVER;
            winner_d = (p1_wins_q > p2_wins_q) ? 2'd1 :
                       (p2_wins_q > p1_wins_q) ? 2'd2 : 2'd3;
          end else begin
            state_d      = ST_INTRO;
            round_num_d  = round_num_q + 3'd1;
            w_load_round = 1'b1;
          end
        end else begin
          phase_cnt_d = phase_cnt_q + 16'd1;
        end
      end

      ST_MATCH_OVER: begin
        if (start) begin
          state_d      = ST_INTRO;
          round_num_d  = 3'd1;
          p1_wins_d    = 2'd0;
          p2_wins_d    = 2'd0;
          winner_d     = 2'd0;
          w_load_round = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_load_round) begin
      p1_hp_d      = c_hp_max;
      p2_hp_d      = c_hp_max;
      round_time_d = c_round_seconds;
      frame_cnt_d  = 16'd0;
      phase_cnt_d  = 16'd0;
    end

    fight_enable_d = (state_d == ST_FIGHT);
    match_over_d   = (state_d == ST_MATCH_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      p1_hp_q        <= c_hp_max;
      p2_hp_q        <= c_hp_max;
      round_time_q   <= c_round_seconds;
      round_num_q    <= 3'd0;
      p1_wins_q      <= 2'd0;
      p2_wins_q      <= 2'd0;
      winner_q       <= 2'd0;
      fight_enable_q <= 1'b0;
      match_over_q   <= 1'b0;
      frame_cnt_q    <= 16'd0;
      phase_cnt_q    <= 16'd0;
    end else if (SCEN) begin
      state_q        <= state_d;
      p1_hp_q        <= p1_hp_d;
      p2_hp_q        <= p2_hp_d;
      round_time_q   <= round_time_d;
      round_num_q    <= round_num_d;
      p1_wins_q      <= p1_wins_d;
      p2_wins_q      <= p2_wins_d;
      winner_q       <= winner_d;
      fight_enable_q <= fight_enable_d;
      match_over_q   <= match_over_d;
      frame_cnt_q    <= frame_cnt_d;
      phase_cnt_q    <= phase_cnt_d;
    end
  end

  assign p1_hp        = p1_hp_q;
  assign p2_hp        = p2_hp_q;
  assign round_time   = round_time_q;
  assign round_state  = state_q;
  assign round_num    = round_num_q;
  assign p1_wins      = p1_wins_q;
  assign p2_wins      = p2_wins_q;
  assign winner       = winner_q;
  assign fight_enable = fight_enable_q;
  assign match_over   = match_over_q;

endmodule
`default_nettype wire

// File: tb/tb_round_manager.sv
`default_nettype none
// ============================================================================
// Module   : tb_round_manager
// Purpose  : Vector table, directed match sequences and a randomized run
//            against an arithmetic reference model for round_manager.
// Revision : 1.0 - initial release
// ============================================================================
module tb_round_manager;

  localparam int HP_MAX         = 100;
  localparam int DMG_LIGHT      = 8;
  localparam int DMG_HEAVY      = 14;
  localparam int FRAMES_PER_SEC = 60;
  localparam int ROUND_SECONDS  = 99;
  localparam int INTRO_FRAMES   = 120;
  localparam int KO_FRAMES      = 90;
  localparam int WINS_TO_MATCH  = 2;
  localparam int MAX_ROUNDS     = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       SCEN = 1'b0;
  logic       start = 1'b0;
  logic       p1_hit_event = 1'b0;
  logic       p2_hit_event = 1'b0;
  logic [1:0] p1_attack_type = 2'd0;
  logic [1:0] p2_attack_type = 2'd0;
  logic [7:0] p1_hp, p2_hp;
  logic [6:0] round_time;
  logic [2:0] round_state, round_num;
  logic [1:0] p1_wins, p2_wins, winner;
  logic       fight_enable, match_over;

  int checks = 0;
  int failures = 0;

  round_manager dut (
    .clk(clk), .reset(reset), .SCEN(SCEN), .start(start),
    .p1_hit_event(p1_hit_event), .p2_hit_event(p2_hit_event),
    .p1_attack_type(p1_attack_type), .p2_attack_type(p2_attack_type),
    .p1_hp(p1_hp), .p2_hp(p2_hp), .round_time(round_time),
    .round_state(round_state), .round_num(round_num),
    .p1_wins(p1_wins), .p2_wins(p2_wins),
    .fight_enable(fight_enable), .match_over(match_over), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit sc; bit h1; bit h2; int t1; int t2; int e1; int e2;
  } vec_t;
  vec_t tbl[7];

  // Reference model state: whole-match view, timer derived from fight ticks.
  int m_st, m_hp1, m_hp2, m_time, m_rnd, m_w1, m_w2, m_win, m_ticks;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input bit sc, input bit st, input bit h1, input bit h2,
                     input int t1, input int t2);
    SCEN = sc; start = st; p1_hit_event = h1; p2_hit_event = h2;
    p1_attack_type = 2'(t1); p2_attack_type = 2'(t2);
    @(posedge clk); #1;
    SCEN = 1'b0; start = 1'b0; p1_hit_event = 1'b0; p2_hit_event = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
  endtask

  function automatic int dmg(input int t);
    return (t == 2) ? DMG_HEAVY : DMG_LIGHT;
  endfunction

  task automatic m_reset();
    m_st = 0; m_hp1 = HP_MAX; m_hp2 = HP_MAX; m_time = ROUND_SECONDS;
    m_rnd = 0; m_w1 = 0; m_w2 = 0; m_win = 0; m_ticks = 0;
  endtask

  task automatic m_new_round(input int r);
    m_st = 1; m_rnd = r; m_hp1 = HP_MAX; m_hp2 = HP_MAX;
    m_time = ROUND_SECONDS; m_ticks = 0;
  endtask

  task automatic m_step(input bit rst, input bit sc, input bit st, input bit h1,
                        input bit h2, input int t1, input int t2);
    if (rst) begin m_reset(); return; end
    if (!sc) return;
    case (m_st)
      0: if (st) m_new_round(1);
      1: begin
        m_ticks++;
        if (m_ticks == INTRO_FRAMES) begin m_st = 2; m_ticks = 0; end
      end
      2: begin
        if (h1) m_hp1 = (m_hp1 > dmg(t2)) ? m_hp1 - dmg(t2) : 0;
        if (h2) m_hp2 = (m_hp2 > dmg(t1)) ? m_hp2 - dmg(t1) : 0;
        m_ticks++;
        m_time = ROUND_SECONDS - m_ticks / FRAMES_PER_SEC;
        if (m_hp1 == 0 || m_hp2 == 0 || m_time == 0) begin
          // The KO player has 0 HP, so comparing HP covers KO, time-out and draws.
          if (m_hp1 > m_hp2) m_w1++;
          else if (m_hp2 > m_hp1) m_w2++;
          m_st = 3; m_ticks = 0;
        end
      end
      3: begin
        m_ticks++;
        if (m_ticks == KO_FRAMES) begin
          m_ticks = 0;
          if (m_w1 == WINS_TO_MATCH || m_w2 == WINS_TO_MATCH || m_rnd == MAX_ROUNDS) begin
            m_st = 4;
            m_win = (m_w1 > m_w2) ? 1 : (m_w2 > m_w1) ? 2 : 3;
          end else begin
            m_new_round(m_rnd + 1);
          end
        end
      end
      4: if (st) begin m_w1 = 0; m_w2 = 0; m_win = 0; m_new_round(1); end
      default: ;
    endcase
  endtask

  task automatic run_random(input int n);
    bit r, sc, st, h1, h2;
    int t1, t2;
    logic [36:0] act_v, exp_v;
    m_reset();
    for (int i = 0; i < n; i++) begin
      r  = (i == 0) || ($urandom_range(2999) == 0);
      sc = ($urandom_range(3) != 0);
      st = ($urandom_range(19) == 0);
      h1 = ($urandom_range(5) == 0);
      h2 = ($urandom_range(5) == 0);
      t1 = int'($urandom_range(3));
      t2 = int'($urandom_range(3));
      reset = r; SCEN = sc; start = st; p1_hit_event = h1; p2_hit_event = h2;
      p1_attack_type = 2'(t1); p2_attack_type = 2'(t2);
      @(posedge clk);
      m_step(r, sc, st, h1, h2, t1, t2);
      #1;
      act_v = {p1_hp, p2_hp, round_time, round_state, round_num, p1_wins, p2_wins,
               fight_enable, match_over, winner};
      exp_v = {8'(m_hp1), 8'(m_hp2), 7'(m_time), 3'(m_st), 3'(m_rnd), 2'(m_w1),
               2'(m_w2), (m_st == 2), (m_st == 4), 2'(m_win)};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL random cycle %0d: got %h expected %h", i, act_v, exp_v);
      end
    end
    reset = 1'b0; SCEN = 1'b0; start = 1'b0; p1_hit_event = 1'b0; p2_hit_event = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1, 0, 1, 2, 0, 100, 86};
    tbl[1] = '{1, 1, 0, 0, 1,  92, 86};
    tbl[2] = '{1, 1, 1, 0, 3,  84, 78};
    tbl[3] = '{1, 0, 0, 2, 2,  84, 78};
    tbl[4] = '{1, 1, 1, 1, 2,  70, 70};
    tbl[5] = '{0, 1, 1, 2, 2,  70, 70};
    tbl[6] = '{1, 0, 1, 2, 0,  70, 56};

    @(posedge clk); #1;
    reset = 1'b1;
    cyc(1, 1, 1, 1, 2, 2);
    reset = 1'b0;
    chk("reset_state", round_state, 0);
    chk("reset_p1_hp", p1_hp, HP_MAX);
    chk("reset_p2_hp", p2_hp, HP_MAX);
    chk("reset_time", round_time, ROUND_SECONDS);
    chk("reset_round", round_num, 0);
    chk("reset_wins", {p1_wins, p2_wins}, 0);
    chk("reset_flags", {fight_enable, match_over, winner}, 0);

    cyc(1, 1, 0, 0, 0, 0);
    chk("start_state", round_state, 1);
    chk("start_round", round_num, 1);
    ticks(INTRO_FRAMES - 1);
    chk("intro_last_tick", round_state, 1);
    ticks(1);
    chk("fight_state", round_state, 2);
    chk("fight_enable", fight_enable, 1);
    chk("fight_hp", {p1_hp, p2_hp}, {8'd100, 8'd100});
    chk("fight_time", round_time, 99);

    for (int i = 0; i < 7; i++) begin
      cyc(tbl[i].sc, 0, tbl[i].h1, tbl[i].h2, tbl[i].t1, tbl[i].t2);
      chk($sformatf("vec%0d_p1_hp", i), p1_hp, tbl[i].e1);
      chk($sformatf("vec%0d_p2_hp", i), p2_hp, tbl[i].e2);
      chk($sformatf("vec%0d_state", i), round_state, 2);
    end
    cyc(1, 1, 0, 0, 0, 0);
    chk("start_ignored_fight", {round_state, round_num}, {3'd2, 3'd1});

    // Round 1: P2 driven to 6 HP, then a heavy hit must saturate at 0.
    cyc(1, 0, 0, 1, 2, 0); cyc(1, 0, 0, 1, 2, 0);
    cyc(1, 0, 0, 1, 1, 0); cyc(1, 0, 0, 1, 2, 0);
    chk("p2_hp_6", p2_hp, 6);
    cyc(1, 0, 0, 1, 2, 0);
    chk("ko_p2_hp_sat", p2_hp, 0);
    chk("ko_state", round_state, 3);
    chk("ko_p1_wins", p1_wins, 1);
    chk("ko_fight_enable", fight_enable, 0);
    cyc(1, 0, 1, 0, 0, 2);
    chk("hit_ignored_ko", p1_hp, 70);
    ticks(KO_FRAMES - 2);
    chk("ko_held", round_state, 3);
    ticks(1);
    chk("r2_intro", {round_state, round_num}, {3'd1, 3'd2});
    chk("r2_hp", {p1_hp, p2_hp}, {8'd100, 8'd100});
    chk("r2_time", round_time, 99);

    // Round 2: simultaneous final light hits at 8/8 -> draw.
    ticks(INTRO_FRAMES);
    for (int i = 0; i < 6; i++) cyc(1, 0, 1, 1, 2, 2);
    cyc(1, 0, 1, 1, 1, 1);
    chk("hp_8_8", {p1_hp, p2_hp}, {8'd8, 8'd8});
    cyc(1, 0, 1, 1, 0, 0);
    chk("draw_hp", {p1_hp, p2_hp}, 0);
    chk("draw_state", round_state, 3);
    chk("draw_wins", {p1_wins, p2_wins}, {2'd1, 2'd0});
    ticks(KO_FRAMES);
    chk("r3_intro", {round_state, round_num}, {3'd1, 3'd3});

    // Round 3: P1 knocked out by heavy hits.
    ticks(INTRO_FRAMES);
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 0, 0, 2);
    chk("r3_ko", {round_state, p1_hp, p2_wins}, {3'd3, 8'd0, 2'd1});
    ticks(KO_FRAMES);
    chk("r4_intro", {round_state, round_num}, {3'd1, 3'd4});

    // Round 4: time-out at 50/70.
    ticks(INTRO_FRAMES);
    cyc(1, 0, 1, 0, 0, 2); cyc(1, 0, 1, 0, 0, 2); cyc(1, 0, 1, 0, 0, 2); cyc(1, 0, 1, 0, 0, 1);
    cyc(1, 0, 0, 1, 2, 0); cyc(1, 0, 0, 1, 1, 0); cyc(1, 0, 0, 1, 1, 0);
    chk("r4_hp", {p1_hp, p2_hp}, {8'd50, 8'd70});
    ticks(FRAMES_PER_SEC - 8);
    chk("time_before_dec", round_time, 99);
    ticks(1);
    chk("time_first_dec", round_time, 98);
    ticks(ROUND_SECONDS * FRAMES_PER_SEC - FRAMES_PER_SEC - 1);
    chk("time_last_sec", {round_state, round_time}, {3'd2, 7'd1});
    ticks(1);
    chk("timeout_state", {round_state, round_time}, {3'd3, 7'd0});
    chk("timeout_wins", {p1_wins, p2_wins}, {2'd1, 2'd2});
    ticks(KO_FRAMES);
    chk("match_over_p2", {round_state, winner, match_over, fight_enable},
        {3'd4, 2'd2, 1'b1, 1'b0});
    ticks(5);
    chk("match_over_hold", {round_state, winner}, {3'd4, 2'd2});

    // Restart, then five drawn rounds -> draw match.
    cyc(1, 1, 0, 0, 0, 0);
    chk("restart", {round_state, round_num, p1_wins, p2_wins, winner},
        {3'd1, 3'd1, 2'd0, 2'd0, 2'd0});
    for (int r = 1; r <= 5; r++) begin
      ticks(INTRO_FRAMES);
      for (int i = 0; i < 8; i++) cyc(1, 0, 1, 1, 2, 2);
      chk($sformatf("draw_round%0d", r), {round_state, round_num, p1_wins, p2_wins},
          {3'd3, 3'(r), 2'd0, 2'd0});
      ticks(KO_FRAMES);
    end
    chk("draw_match", {round_state, winner, match_over}, {3'd4, 2'd3, 1'b1});
    cyc(1, 1, 0, 0, 0, 0);
    chk("restart2", {round_state, round_num, p1_wins, p2_wins, winner},
        {3'd1, 3'd1, 2'd0, 2'd0, 2'd0});

    ticks(INTRO_FRAMES);
    cyc(1, 0, 0, 1, 2, 0);
    chk("pre_reset_hp", p2_hp, 86);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    chk("mid_reset", {round_state, p1_hp, p2_hp, round_time, round_num, fight_enable},
        {3'd0, 8'd100, 8'd100, 7'd99, 3'd0, 1'b0});

    run_random(30000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/round_manager.md
# round_manager

Round and match controller that sits directly downstream of `game_resolver`. It consumes the per-player hit events and attacker types, keeps hit points, runs the round clock, and detects KO and time-out. It sequences the round states (intro, fight, KO freeze, match over) and drives `fight_enable`, which gates player input/state logic, plus HUD-facing HP, timer and win counts.

## Interface
- `HP_MAX`, 100: starting HP per round (≤255)
- `DMG_LIGHT`, 8: HP removed by an ATK1 hit (or attacker type 0/3)
- `DMG_HEAVY`, 14: HP removed by an ATK2 hit
- `FRAMES_PER_SEC`, 60: SCEN ticks per timer second
- `ROUND_SECONDS`, 99: round timer start value (≤127)
- `INTRO_FRAMES`, 120: SCEN ticks spent in INTRO
- `KO_FRAMES`, 90: SCEN ticks spent in KO freeze
- `WINS_TO_MATCH`, 2: round wins needed to take the match
- `MAX_ROUNDS`, 5: hard cap on rounds per match

Ports:
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high; overrides `SCEN`
- `SCEN` in 1: frame-tick enable; all state advances only when high
- `start` in 1: begin match (honoured in IDLE and MATCH_OVER only)
- `p1_hit_event`, `p2_hit_event` in 1 each: 1-cycle hit pulses from resolver (player named was hit)
- `p1_attack_type`, `p2_attack_type` in 2 each: attacker type, 1=ATK1, 2=ATK2
- `p1_hp`, `p2_hp` out 8 each: current HP
- `round_time` out 7: seconds remaining
- `round_state` out 3: 0 IDLE, 1 INTRO, 2 FIGHT, 3 KO, 4 MATCH_OVER
- `round_num` out 3: current round, 1-based; 0 in IDLE
- `p1_wins`, `p2_wins` out 2 each: rounds won this match
- `fight_enable` out 1: high only in FIGHT
- `match_over` out 1: high only in MATCH_OVER
- `winner` out 2: 0 none, 1 P1, 2 P2, 3 draw. Valid in MATCH_OVER; 0 otherwise.

## Operation
- Reset values: state IDLE; HP = HP_MAX; `round_time` = ROUND_SECONDS; wins, `round_num`, `winner`, `fight_enable`, `match_over` all 0; internal frame/phase counters 0.
- IDLE: on SCEN with `start` high, go to INTRO with `round_num`=1 and counters cleared.
- INTRO: count INTRO_FRAMES SCEN ticks, then go to FIGHT. HP and timer are held at their start values.
- FIGHT, damage:
  - A `pN_hit_event` reduces `pN_hp` by the damage for the opponent's attack type sampled on the same SCEN. Type 2 uses DMG_HEAVY; any other type uses DMG_LIGHT.
  - HP saturates at 0 and never wraps.
  - Simultaneous hits on both players are both applied on that SCEN.
- FIGHT, timer:
  - The frame counter counts 0..FRAMES_PER_SEC-1 and wraps.
  - On each wrap `round_time` decrements.
  - When `round_time` reaches 0, the round ends by time-out.
- Round end is evaluated on the SCEN edge using post-damage HP:
  - If either HP is 0: P2 only at 0 gives P1 the round; P1 only at 0 gives P2 the round; both at 0 is a draw.
  - Otherwise, on time-out, the higher HP wins and equal HP is a draw.
  - A KO and a time-out on the same SCEN resolve by the KO rule.
  - The winner's win count increments; a draw awards nothing. Go to KO.
- KO: hold all values frozen for KO_FRAMES SCEN ticks, then:
  - If a win count equals WINS_TO_MATCH, go to MATCH_OVER with `winner` = that player.
  - Else if `round_num` = MAX_ROUNDS, go to MATCH_OVER with `winner` by comparing win counts (equal gives 3).
  - Else go to INTRO, increment `round_num`, reload HP and `round_time`, clear the frame counter.
- MATCH_OVER: hold all outputs. `start` on SCEN clears wins and sets `winner` to 0, then enters INTRO with round 1.
- Hit events outside FIGHT are ignored. `start` outside IDLE and MATCH_OVER is ignored.

## Timing
- All outputs are registered. A hit on SCEN cycle n appears on HP at n+1.
- The state transition to KO happens on the same edge as HP reaching 0, so `fight_enable` drops at n+1.
- INTRO lasts exactly INTRO_FRAMES SCEN ticks; FIGHT is first visible after the last tick.
- The first decrement of `round_time` occurs FRAMES_PER_SEC SCEN ticks into FIGHT.
- With `SCEN` low, nothing changes; pulses arriving while `SCEN` is low are dropped.
- Reset mid-round returns to the reset values on the next clock, regardless of `SCEN`.

## Test plan
- Reset, then `start`, then 120 SCEN ticks: `round_state` 0→1→2, `fight_enable`=1, HP 100/100, `round_time`=99, `round_num`=1.
- In FIGHT, `p2_hit_event` with `p1_attack_type`=2: `p2_hp` goes 100→86 next cycle. Then `p1_hit_event` with `p2_attack_type`=1: `p1_hp` 100→92.
- `p2_hp`=6 receives a heavy hit: `p2_hp`=0 (no wrap), state KO, `p1_wins`=1. After 90 ticks: INTRO, `round_num`=2, HP 100/100.
- Both players hit on the same SCEN at HP 8/8 with light attacks: both HP 0, draw, win counts unchanged.
- Time-out with HP 50/70 after 99×60 FIGHT ticks: P2 wins the round. With P2 already at 1 win, after KO: MATCH_OVER, `winner`=2, `match_over`=1.
- Five draw rounds: MATCH_OVER with `winner`=3. Then `start`: INTRO, round 1, wins 0. `reset` asserted mid-FIGHT: all reset values on the next clock.
